// File: rtl/de2_stream_pkg.sv
// Shared tags, burst FSM states and word builders for the DE2 32-bit stream.
package de2_stream_pkg;

  localparam logic [3:0] TAG_CAPTURE = 4'h1;
  localparam logic [3:0] TAG_BURST   = 4'h2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

  function automatic logic [31:0] capture_word(input logic [17:0] sw);
    return {TAG_CAPTURE, 10'b0, sw};
  endfunction

  function automatic logic [31:0] burst_word(input logic [15:0] seq);
    return {TAG_BURST, 12'b0, seq};
  endfunction

endpackage

// File: rtl/debounce_v1.sv
// Active-low button conditioner: 2-flop synchronizer plus stability counter,
// emitting a single-cycle pulse when a press has been stable for CYCLES clocks.
module debounce_v1 #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // The debounced level only changes after the synchronized input has
  // disagreed with it for CYCLES consecutive clocks; release is filtered too.
  assign flip    = (sync_q[1] != stable_q) && (cnt_q == CW'(CYCLES - 1));
  assign press_o = flip && !sync_q[1];

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((sync_q[1] == stable_q) || flip) cnt_d = '0;
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values;
  // blocking would collapse the two synchronizer stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn_n_i};
      cnt_q    <= cnt_d;
      if (flip) stable_q <= sync_q[1];
    end
  end

endmodule

// File: rtl/avst_source_v1.sv
// Avalon-ST source: switch captures and sequence-numbered bursts are queued in
// an inline FIFO and presented on a zero-latency valid/ready interface.
module avst_source_v1
  import de2_stream_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int BURST_LEN       = 16,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] data_out,
  output logic        valid,
  input  logic        ready,
  input  logic [17:0] switches,
  input  logic [3:0]  buttons,
  output logic [7:0]  leds_green,
  output logic [17:0] leds_red,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic cap_p, burst_p, flush_p;

  debounce_v1 #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_cap (
    .clk(clk), .rst_n(rst), .btn_n_i(buttons[0]), .press_o(cap_p));
  debounce_v1 #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_burst (
    .clk(clk), .rst_n(rst), .btn_n_i(buttons[1]), .press_o(burst_p));
  debounce_v1 #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_flush (
    .clk(clk), .rst_n(rst), .btn_n_i(buttons[2]), .press_o(flush_p));

  logic unused_key3;
  assign unused_key3 = buttons[3];

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  burst_state_e  state_q, state_d;
  logic [15:0]   remain_q, remain_d;
  logic [15:0]   seq_q, seq_d;
  logic [7:0]    drop_q;
  logic [17:0]   leds_red_q;

  logic        pop, space, cap_push, cap_drop, burst_push, push;
  logic [31:0] push_word;

  assign pop        = (count_q != '0) && ready;
  assign space      = (count_q < CW'(DEPTH)) || pop;
  assign cap_push   = cap_p && space;
  assign cap_drop   = cap_p && !space;
  // A capture owns the single write port this cycle; the burst word retries.
  assign burst_push = (state_q == ST_BURST) && space && !cap_p;
  assign push       = cap_push || burst_push;
  assign push_word  = cap_push ? capture_word(switches) : burst_word(seq_q);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    seq_d    = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (burst_p) begin
          state_d  = ST_BURST;
          remain_d = 16'(BURST_LEN);
        end
      end
      ST_BURST: begin
        if (burst_push) begin
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (burst_push && !flush_p) seq_d = seq_q + 16'd1;
    if (flush_p) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      leds_red_q <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      seq_q      <= seq_d;
      leds_red_q <= switches;
      if (cap_drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      if (flush_p) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; data_out is masked while empty, so stale
  // entries are never observable and the array maps onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push && !flush_p) mem_q[wr_ptr_q] <= push_word;
  end

  assign valid      = (count_q != '0);
  assign data_out   = valid ? mem_q[rd_ptr_q] : 32'h0;
  assign leds_green = {(state_q == ST_BURST), (count_q == CW'(DEPTH)), 2'b00, 4'(count_q)};
  assign leds_red   = leds_red_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_avst_source_v1.sv
// Self-checking bench for avst_source_v1: directed scenarios plus randomized
// ready/capture/reset traffic scored against a queue-based stream model.
module tb_avst_source_v1;

  localparam int DEPTH = 8;
  localparam int BLEN  = 16;
  localparam int DEB   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_out;
  logic        valid;
  logic        ready;
  logic [17:0] switches;
  logic [3:0]  buttons;
  logic [7:0]  leds_green;
  logic [17:0] leds_red;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_seq;      // model of the free-running burst sequence number
  logic [31:0] obs_q[$];     // words observed crossing the interface
  int          obs_t[$];     // cycle stamp of each observed transfer
  int          cyc = 0;

  always #5 clk = ~clk;

  avst_source_v1 #(.DEPTH(DEPTH), .BURST_LEN(BLEN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .data_out(data_out), .valid(valid), .ready(ready),
    .switches(switches), .buttons(buttons), .leds_green(leds_green),
    .leds_red(leds_red), .drop_count(drop_count));

  always @(negedge clk) begin
    cyc++;
    if (rst && valid && ready) begin
      obs_q.push_back(data_out);
      obs_t.push_back(cyc);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int k, input int hold = 12);
    buttons[k] = 1'b0;
    tick(hold);
    buttons[k] = 1'b1;
    tick(hold);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_t.delete();
  endtask

  function automatic logic [31:0] bword(input logic [15:0] s);
    return 32'h2000_0000 + {16'h0, s};
  endfunction

  // Compare the first n observed words against consecutive burst words.
  task automatic expect_burst_run(input string name, input int first, input int n);
    int bad = 0;
    logic [31:0] got = '0, want = '0;
    for (int i = 0; i < n; i++) begin
      if (first + i < obs_q.size() && bad == 0) begin
        if (obs_q[first+i] !== bword(exp_seq)) begin
          bad = 1; got = obs_q[first+i]; want = bword(exp_seq);
        end
      end
      exp_seq = exp_seq + 16'd1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ready = 1'b0; switches = '0; buttons = 4'hF;
    exp_seq = '0;
    tick(3);
    checks++;
    if ({valid, data_out} !== 33'h0) begin
      errors++; $display("FAIL reset_stream: got %b/%h expected 0/0", valid, data_out);
    end
    checks++;
    if ({leds_green, leds_red, drop_count} !== 34'h0) begin
      errors++; $display("FAIL reset_leds: got %h/%h/%h expected 0", leds_green, leds_red, drop_count);
    end
    rst = 1'b1;
    tick(4);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b expected 0", valid);
    end
  endtask

  task automatic test_capture();
    switches = 18'h2ABCD; ready = 1'b1;
    tick();
    clear_obs();
    press(0);
    tick(10);
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL capture_count: got %0d words expected 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== 32'h1002ABCD) begin
        errors++; $display("FAIL capture_word: got %h expected 1002abcd", obs_q[0]);
      end
    end
    checks++;
    if (leds_red !== 18'h2ABCD) begin
      errors++; $display("FAIL leds_red: got %h expected 2abcd", leds_red);
    end
  endtask

  task automatic test_burst();
    int gap_bad = 0;
    ready = 1'b1;
    clear_obs();
    buttons[1] = 1'b0;
    tick(12);
    checks++;
    if (leds_green[7] !== 1'b1) begin
      errors++; $display("FAIL burst_led_active: got %b expected 1", leds_green[7]);
    end
    buttons[1] = 1'b1;
    tick(30);
    checks++;
    if (obs_q.size() != BLEN) begin
      errors++; $display("FAIL burst_count: got %0d expected %0d", obs_q.size(), BLEN);
    end
    expect_burst_run("burst_words", 0, BLEN);
    for (int i = 1; i < obs_t.size(); i++)
      if (obs_t[i] != obs_t[i-1] + 1) gap_bad = 1;
    checks++;
    if (gap_bad != 0) begin
      errors++; $display("FAIL burst_throughput: got gap=1 expected gap=0");
    end
    checks++;
    if ({leds_green[7], valid} !== 2'b00) begin
      errors++; $display("FAIL burst_end: got led7/valid %b%b expected 00", leds_green[7], valid);
    end
  endtask

  task automatic test_full_and_drop();
    logic [31:0] head;
    ready = 1'b0;
    clear_obs();
    press(1);
    tick(5);
    head = bword(exp_seq);
    checks++;
    if (leds_green !== 8'hC8) begin
      errors++; $display("FAIL full_leds: got %h expected c8", leds_green);
    end
    checks++;
    if ({valid, data_out} !== {1'b1, head}) begin
      errors++; $display("FAIL full_head: got %b/%h expected 1/%h", valid, data_out, head);
    end
    for (int i = 0; i < 3; i++) begin
      switches = 18'($urandom);
      press(0, 8);
    end
    checks++;
    if (drop_count !== 8'd3) begin
      errors++; $display("FAIL drop_three: got %0d expected 3", drop_count);
    end
    checks++;
    if ({leds_green, data_out} !== {8'hC8, head}) begin
      errors++; $display("FAIL drop_unchanged: got %h/%h expected c8/%h", leds_green, data_out, head);
    end
    for (int i = 0; i < 253; i++) press(0, 8);
    checks++;
    if (drop_count !== 8'hFF) begin
      errors++; $display("FAIL drop_saturate: got %h expected ff", drop_count);
    end
    ready = 1'b1;
    tick(40);
    checks++;
    if (obs_q.size() != BLEN) begin
      errors++; $display("FAIL drain_count: got %0d expected %0d", obs_q.size(), BLEN);
    end
    expect_burst_run("drain_order", 0, BLEN);
    checks++;
    if (leds_green !== 8'h00) begin
      errors++; $display("FAIL drain_leds: got %h expected 00", leds_green);
    end
  endtask

  task automatic test_flush();
    ready = 1'b0;
    clear_obs();
    press(1);
    tick(3);
    ready = 1'b1;
    tick(5);
    ready = 1'b0;
    checks++;
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL flush_prepop: got %0d expected 5", obs_q.size());
    end
    expect_burst_run("flush_prepop_words", 0, 5);
    exp_seq = exp_seq + 16'd8;  // the five pops let five more burst words in
    checks++;
    if (leds_green !== 8'hC8) begin
      errors++; $display("FAIL flush_before: got %h expected c8", leds_green);
    end
    press(2);
    checks++;
    if ({valid, leds_green} !== 9'h0) begin
      errors++; $display("FAIL flush_after: got %b/%h expected 0/00", valid, leds_green);
    end
    ready = 1'b1;
    clear_obs();
    press(1);
    tick(30);
    checks++;
    if (obs_q.size() != BLEN) begin
      errors++; $display("FAIL flush_reburst_count: got %0d expected %0d", obs_q.size(), BLEN);
    end
    expect_burst_run("flush_seq_kept", 0, BLEN);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int          cap_at = int'($urandom_range(0, 20));
      logic [17:0] sw     = 18'($urandom);
      logic [7:0]  drops0 = drop_count;
      int          caps = 0, bursts = 0, bad = 0;
      clear_obs();
      switches = sw;
      for (int c = 0; c < 70; c++) begin
        ready      = 1'($urandom_range(0, 1));
        buttons[1] = (c < 12) ? 1'b0 : 1'b1;
        buttons[0] = (c >= cap_at && c < cap_at + 12) ? 1'b0 : 1'b1;
        tick();
      end
      ready = 1'b1;
      tick(40);
      foreach (obs_q[i]) begin
        if (obs_q[i][31:28] == 4'h1) begin
          caps++;
          if (obs_q[i] !== (32'h1000_0000 | {14'h0, sw})) bad = 1;
        end else if (obs_q[i] === bword(exp_seq)) begin
          bursts++;
          exp_seq = exp_seq + 16'd1;
        end else begin
          bad = 1;
        end
      end
      checks++;
      if (bad != 0 || bursts != BLEN) begin
        errors++; $display("FAIL rand_stream it%0d: got bursts=%0d bad=%0d expected %0d/0", it, bursts, bad, BLEN);
      end
      checks++;
      if (caps + int'(drop_count - drops0) != 1) begin
        errors++; $display("FAIL rand_capture it%0d: got caps=%0d drops=%0d expected total 1", it, caps, drop_count - drops0);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    ready = 1'b0;
    buttons[1] = 1'b0;
    tick(12);
    buttons[1] = 1'b1;
    ready = 1'b1;
    tick(int'($urandom_range(0, 5)));
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({valid, data_out, leds_green, leds_red, drop_count} !== 67'h0) begin
      errors++; $display("FAIL reset_async: got %b/%h/%h/%h/%h expected all 0", valid, data_out, leds_green, leds_red, drop_count);
    end
    tick(2);
    rst = 1'b1;
    exp_seq = '0;
    clear_obs();
    tick(20);
    checks++;
    if (obs_q.size() != 0 || valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_spurious: got %0d words valid=%b expected 0/0", obs_q.size(), valid);
    end
    press(1);
    tick(30);
    checks++;
    if (obs_q.size() != BLEN) begin
      errors++; $display("FAIL reset_reburst_count: got %0d expected %0d", obs_q.size(), BLEN);
    end
    expect_burst_run("reset_seq_zero", 0, BLEN);
  endtask

  initial begin
    test_reset();
    test_capture();
    test_burst();
    test_full_and_drop();
    test_flush();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
